// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA raster timing with a pixel request port.
// Stage 0 decodes the raster counters, stage 1 issues (x, y) requests to the
// pixel source, and the sync/enable/marker bits ride a delay line so they
// arrive at the output register together with the returned pixel.
module vga_timing_gen #(
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FP    = 10,
    parameter bit          HS_POL  = 1'b1,
    parameter bit          VS_POL  = 1'b1,
    parameter int unsigned V_CLIP  = 480,
    parameter int unsigned PIX_LAT = 1,
    parameter int unsigned CW      = 1,
    parameter int unsigned XW      = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3*CW-1:0] pix_rgb,
    output logic            req_valid,
    output logic [XW-1:0]   req_x,
    output logic [XW-1:0]   req_y,
    output logic [3*CW-1:0] vga_rgb,
    output logic            vga_de,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            frame_start,
    output logic            line_start
);

    // Region boundaries, all as XW-bit unsigned values.
    localparam logic [XW-1:0] H_TOT_M1 = XW'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam logic [XW-1:0] V_TOT_M1 = XW'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [XW-1:0] HS_END   = XW'(H_SYNC);
    localparam logic [XW-1:0] VS_END   = XW'(V_SYNC);
    localparam logic [XW-1:0] HA_BEG   = XW'(H_SYNC + H_BP);
    localparam logic [XW-1:0] HA_END   = XW'(H_SYNC + H_BP + H_ACT);
    localparam logic [XW-1:0] VA_BEG   = XW'(V_SYNC + V_BP);
    localparam logic [XW-1:0] VA_END   = XW'(V_SYNC + V_BP + V_ACT);
    localparam logic [XW-1:0] CLIP_W   = XW'(V_CLIP);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic sof;
        logic sol;
    } tmg_t;

    logic [XW-1:0] hcnt, vcnt;
    logic [XW-1:0] x0, y0;
    tmg_t          tmg0;
    tmg_t          tmg_d;
    tmg_t          vld_pipe [PIX_LAT:0];

    // Raster counters: vcnt advances on the last clock of each line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_TOT_M1) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_TOT_M1) ? '0 : vcnt + XW'(1);
        end else begin
            hcnt <= hcnt + XW'(1);
        end
    end

    // Stage 0: decode sync, active window (with row clip) and coordinates.
    always_comb begin
        x0       = hcnt - HA_BEG;
        y0       = vcnt - VA_BEG;
        tmg0.hs  = hcnt < HS_END;
        tmg0.vs  = vcnt < VS_END;
        tmg0.act = (hcnt >= HA_BEG) && (hcnt < HA_END) &&
                   (vcnt >= VA_BEG) && (vcnt < VA_END) && (y0 < CLIP_W);
        tmg0.sof = tmg0.act && (x0 == '0) && (y0 == '0);
        tmg0.sol = tmg0.act && (x0 == '0);
    end

    // Stage 1: pixel request; coordinates hold their last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_valid <= 1'b0;
            req_x     <= '0;
            req_y     <= '0;
        end else begin
            req_valid <= tmg0.act;
            if (tmg0.act) begin
                req_x <= x0;
                req_y <= y0;
            end
        end
    end

    // Delay line: PIX_LAT+1 stages so timing meets the returned pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(PIX_LAT); i++) vld_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= tmg0;
            for (int i = 1; i <= int'(PIX_LAT); i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign tmg_d = vld_pipe[PIX_LAT];

    // Output stage: apply polarity and blank colour outside the active window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_de      <= 1'b0;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            vga_hs      <= tmg_d.hs ? HS_POL : ~HS_POL;
            vga_vs      <= tmg_d.vs ? VS_POL : ~VS_POL;
            vga_de      <= tmg_d.act;
            vga_rgb     <= tmg_d.act ? pix_rgb : '0;
            frame_start <= tmg_d.sof;
            line_start  <= tmg_d.sol;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (A: tiny timing,
// active-low syncs, zero latency; B: latency 3, row clip, wider colour).
// A raster model built from plain position arithmetic predicts every output
// on every clock; a vector table and frame-level counts pin down corners.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A
    logic [2:0]  a_pix, a_rgb;
    logic        a_rv, a_de, a_hs, a_vs, a_fs, a_ls;
    logic [11:0] a_rx, a_ry;
    // Instance B
    logic [5:0]  b_pix, b_rgb;
    logic        b_rv, b_de, b_hs, b_vs, b_fs, b_ls;
    logic [7:0]  b_rx, b_ry;

    vga_timing_gen #(
        .H_SYNC(2), .H_BP(1), .H_ACT(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .V_CLIP(3), .PIX_LAT(0), .CW(1), .XW(12)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_rgb(a_pix),
        .req_valid(a_rv), .req_x(a_rx), .req_y(a_ry),
        .vga_rgb(a_rgb), .vga_de(a_de), .vga_hs(a_hs), .vga_vs(a_vs),
        .frame_start(a_fs), .line_start(a_ls)
    );

    vga_timing_gen #(
        .H_SYNC(3), .H_BP(2), .H_ACT(6), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACT(5), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .V_CLIP(3), .PIX_LAT(3), .CW(2), .XW(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_rgb(b_pix),
        .req_valid(b_rv), .req_x(b_rx), .req_y(b_ry),
        .vga_rgb(b_rgb), .vga_de(b_de), .vga_hs(b_hs), .vga_vs(b_vs),
        .frame_start(b_fs), .line_start(b_ls)
    );

    typedef struct {
        int hs, hbp, hact, hfp, vs, vbp, vact, vfp, clip, lat, rgbmask;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic        rv;
        logic [15:0] rx, ry;
        logic [7:0]  rgb;
        logic        hs, vs, de, fs, ls;
    } obs_t;

    typedef struct {
        bit act, hsy, vsy;
        int x, y;
    } pos_t;

    typedef struct {
        int   k;
        obs_t e;   // rgb field ignored for table vectors
    } tv_t;

    cfg_t cfg [2];
    int   tab [2][8][8];
    int   mrx [2], mry [2];
    int   hrv [2][16], hrx [2][16], hry [2][16];
    int   k, seg;
    int   checks = 0, failures = 0;
    tv_t  tv [10];
    int   cnt_hs [2], cnt_vs [2], cnt_de [2], cnt_fs [2];
    int   first_rv_b, first_de_b;

    // Raster position p clocks after reset release, from plain arithmetic.
    function automatic pos_t at_pos(cfg_t c, int p);
        pos_t r;
        int ht, vt, h, v;
        ht    = c.hs + c.hbp + c.hact + c.hfp;
        vt    = c.vs + c.vbp + c.vact + c.vfp;
        h     = p % ht;
        v     = (p / ht) % vt;
        r.x   = h - (c.hs + c.hbp);
        r.y   = v - (c.vs + c.vbp);
        r.hsy = h < c.hs;
        r.vsy = v < c.vs;
        r.act = r.x >= 0 && r.x < c.hact && r.y >= 0 && r.y < c.vact && r.y < c.clip;
        return r;
    endfunction

    function automatic obs_t rst_obs(int d);
        obs_t o;
        o    = '0;
        o.hs = ~cfg[d].hpol;
        o.vs = ~cfg[d].vpol;
        return o;
    endfunction

    function automatic obs_t sample(int d);
        obs_t o;
        o = '0;
        if (d == 0) begin
            o.rv = a_rv; o.rx = 16'(a_rx); o.ry = 16'(a_ry); o.rgb = 8'(a_rgb);
            o.hs = a_hs; o.vs = a_vs; o.de = a_de; o.fs = a_fs; o.ls = a_ls;
        end else begin
            o.rv = b_rv; o.rx = 16'(b_rx); o.ry = 16'(b_ry); o.rgb = 8'(b_rgb);
            o.hs = b_hs; o.vs = b_vs; o.de = b_de; o.fs = b_fs; o.ls = b_ls;
        end
        return o;
    endfunction

    task automatic chk(string nm, int kk, obs_t a, obs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s k=%0d got rv=%0d x=%0d y=%0d rgb=%0h hs=%0d vs=%0d de=%0d fs=%0d ls=%0d want rv=%0d x=%0d y=%0d rgb=%0h hs=%0d vs=%0d de=%0d fs=%0d ls=%0d",
                         nm, kk, a.rv, a.rx, a.ry, a.rgb, a.hs, a.vs, a.de, a.fs, a.ls,
                         e.rv, e.rx, e.ry, e.rgb, e.hs, e.vs, e.de, e.fs, e.ls);
        end
    endtask

    task automatic chk_int(string nm, int a, int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    // One clock of checking at the negedge with k clocks since release.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            obs_t e, a, am;
            pos_t p, q;
            int   qi, hi, pv;
            string nm;
            nm = (d == 0) ? "dutA" : "dutB";
            e  = rst_obs(d);
            if (k >= 1) begin
                p = at_pos(cfg[d], k - 1);
                if (p.act) begin mrx[d] = p.x; mry[d] = p.y; end
                e.rv = p.act;
            end
            e.rx = 16'(mrx[d]);
            e.ry = 16'(mry[d]);
            qi = k - (cfg[d].lat + 2);
            if (qi >= 0) begin
                q    = at_pos(cfg[d], qi);
                e.hs = q.hsy ? cfg[d].hpol : ~cfg[d].hpol;
                e.vs = q.vsy ? cfg[d].vpol : ~cfg[d].vpol;
                e.de = q.act;
                e.fs = q.act && q.x == 0 && q.y == 0;
                e.ls = q.act && q.x == 0;
                e.rgb = q.act ? 8'(tab[d][q.x][q.y]) : 8'd0;
            end
            a = sample(d);
            chk(nm, k, a, e);

            if (seg == 0) begin
                if (d == 0) begin
                    am = a; am.rgb = '0;
                    for (int i = 0; i < 10; i++)
                        if (tv[i].k == k) chk("vecA", k, am, tv[i].e);
                end
                if (qi >= 0 && qi < (d == 0 ? 48 : 130)) begin
                    if (a.hs == cfg[d].hpol) cnt_hs[d]++;
                    if (a.vs == cfg[d].vpol) cnt_vs[d]++;
                    if (a.de) cnt_de[d]++;
                    if (a.fs) cnt_fs[d]++;
                end
                if (d == 1 && a.rv && first_rv_b < 0) first_rv_b = k;
                if (d == 1 && a.de && first_de_b < 0) first_de_b = k;
            end

            // Pixel source: return table colour PIX_LAT clocks after a request,
            // random junk otherwise so blanking leakage is exposed.
            hi = k % 16;
            hrv[d][hi] = a.rv; hrx[d][hi] = int'(a.rx); hry[d][hi] = int'(a.ry);
            pv = int'($urandom) & cfg[d].rgbmask;
            if (k >= cfg[d].lat) begin
                hi = (k - cfg[d].lat) % 16;
                if (hrv[d][hi] != 0 && hrx[d][hi] < 8 && hry[d][hi] < 8)
                    pv = tab[d][hrx[d][hi]][hry[d][hi]];
            end
            if (d == 0) a_pix = 3'(pv); else b_pix = 6'(pv);
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            step();
            @(negedge clk);
            k++;
        end
    endtask

    // Asynchronous reset between edges: outputs must drop at once.
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rstA", k, sample(0), rst_obs(0));
        chk("rstB", k, sample(1), rst_obs(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int d = 0; d < 2; d++) begin mrx[d] = 0; mry[d] = 0; end
    endtask

    function automatic obs_t mk(bit rv, int rx, int ry, bit hs, bit vs, bit de, bit fs, bit ls);
        obs_t o;
        o = '0;
        o.rv = rv; o.rx = 16'(rx); o.ry = 16'(ry);
        o.hs = hs; o.vs = vs; o.de = de; o.fs = fs; o.ls = ls;
        return o;
    endfunction

    initial begin
        cfg[0] = '{hs:2, hbp:1, hact:4, hfp:1, vs:1, vbp:1, vact:3, vfp:1,
                   clip:3, lat:0, rgbmask:7, hpol:1'b0, vpol:1'b0};
        cfg[1] = '{hs:3, hbp:2, hact:6, hfp:2, vs:2, vbp:2, vact:5, vfp:1,
                   clip:3, lat:3, rgbmask:63, hpol:1'b1, vpol:1'b1};
        for (int d = 0; d < 2; d++) begin
            mrx[d] = 0; mry[d] = 0;
            cnt_hs[d] = 0; cnt_vs[d] = 0; cnt_de[d] = 0; cnt_fs[d] = 0;
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++)
                    tab[d][x][y] = int'($urandom) & cfg[d].rgbmask;
            for (int i = 0; i < 16; i++) begin hrv[d][i] = 0; hrx[d][i] = 0; hry[d][i] = 0; end
        end
        first_rv_b = -1;
        first_de_b = -1;

        // Instance A vectors (active-low syncs, 8x6 raster, 2-clock output latency).
        //              k          rv rx ry hs vs de fs ls
        tv[0] = '{0,  mk(0, 0, 0, 1, 1, 0, 0, 0)};
        tv[1] = '{2,  mk(0, 0, 0, 0, 0, 0, 0, 0)};
        tv[2] = '{4,  mk(0, 0, 0, 1, 0, 0, 0, 0)};
        tv[3] = '{20, mk(1, 0, 0, 1, 1, 0, 0, 0)};
        tv[4] = '{21, mk(1, 1, 0, 1, 1, 1, 1, 1)};
        tv[5] = '{24, mk(0, 3, 0, 1, 1, 1, 0, 0)};
        tv[6] = '{29, mk(1, 1, 1, 1, 1, 1, 0, 1)};
        tv[7] = '{50, mk(0, 3, 2, 0, 0, 0, 0, 0)};
        tv[8] = '{58, mk(0, 3, 2, 0, 1, 0, 0, 0)};
        tv[9] = '{23, mk(1, 3, 0, 1, 1, 1, 0, 0)};

        rst_n = 1'b0;
        a_pix = '1;
        b_pix = '1;
        k     = 0;
        seg   = 0;
        repeat (2) @(negedge clk);
        chk("inrstA", 0, sample(0), rst_obs(0));
        chk("inrstB", 0, sample(1), rst_obs(1));
        rst_n = 1'b1;
        run(400);

        // Per-frame totals and first-request latency.
        chk_int("A_hs_per_frame", cnt_hs[0], 2 * 6);
        chk_int("A_vs_per_frame", cnt_vs[0], 1 * 8);
        chk_int("A_de_per_frame", cnt_de[0], 4 * 3);
        chk_int("A_fs_per_frame", cnt_fs[0], 1);
        chk_int("B_hs_per_frame", cnt_hs[1], 3 * 10);
        chk_int("B_vs_per_frame", cnt_vs[1], 2 * 13);
        chk_int("B_de_clipped",   cnt_de[1], 6 * 3);
        chk_int("B_fs_per_frame", cnt_fs[1], 1);
        chk_int("B_first_req",    first_rv_b, 4 * 13 + 5 + 1);
        chk_int("B_first_de",     first_de_b, 4 * 13 + 5 + 1 + 4);

        seg = 1;
        mid_reset();
        run(100 + int'($urandom_range(0, 200)));
        mid_reset();
        run(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
